// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed scan driver for a four-digit
// seven-segment display with frame-synchronous pattern latching and
// 3-bit PWM brightness.
//
// Optional feature: define SEG_SCAN_LZB_EN to compile leading-zero
// blanking for digits 2..4. Without it every digit shows its latched pattern.
//
// Handshake: load is a single-cycle strobe with no backpressure. seg1..seg4
// are sampled on every rising edge where load=1. A later strobe in the same
// frame overwrites the earlier one.
module seg_scan_driver #(
  parameter int CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg1,
  input  logic [6:0] seg2,
  input  logic [6:0] seg3,
  input  logic [6:0] seg4,
  input  logic       load,
  input  logic [2:0] bright,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);
  localparam logic [6:0] ZERO_PAT = 7'b0111111;

  logic [TW-1:0] tick;
  logic [2:0]    sub;
  logic [1:0]    dig;
  logic          tick_wrap;
  logic          sub_wrap;
  logic          boundary;

  logic [6:0]    pend [4];
  logic [6:0]    disp [4];
  logic          pflag;

  logic [3:0]    blank;
  logic          en;

  // Wrap and frame-boundary decode from the current counter state.
  always_comb begin
    tick_wrap = (tick == TICK_MAX);
    sub_wrap  = (sub == 3'd7);
    boundary  = tick_wrap && sub_wrap && (dig == 2'd3);
  end

  // Scan counters: tick -> sub-slot -> digit. Reset restarts the scan at digit 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= '0;
      sub  <= '0;
      dig  <= '0;
    end else if (tick_wrap) begin
      tick <= '0;
      sub  <= sub + 3'd1;
      if (sub_wrap) begin
        dig <= dig + 2'd1;
      end
    end else begin
      tick <= tick + TW'(1);
    end
  end

  // Pending/display registers. Display changes only at a frame boundary.
  // A load in the boundary cycle goes straight to the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        pend[k] <= '0;
        disp[k] <= '0;
      end
      pflag <= 1'b0;
    end else if (load) begin
      pend[0] <= seg1;
      pend[1] <= seg2;
      pend[2] <= seg3;
      pend[3] <= seg4;
      if (boundary) begin
        disp[0] <= seg1;
        disp[1] <= seg2;
        disp[2] <= seg3;
        disp[3] <= seg4;
        pflag   <= 1'b0;
      end else begin
        pflag   <= 1'b1;
      end
    end else if (boundary && pflag) begin
      for (int k = 0; k < 4; k++) begin
        disp[k] <= pend[k];
      end
      pflag <= 1'b0;
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // Leading-zero blanking: a digit is blanked when it and every more
  // significant digit show the "0" glyph. Digit 1 always stays lit.
  always_comb begin
    blank    = '0;
    blank[3] = (disp[3] == ZERO_PAT);
    blank[2] = blank[3] && (disp[2] == ZERO_PAT);
    blank[1] = blank[2] && (disp[1] == ZERO_PAT);
  end
`else
  // No blanking in this build: all digits are shown as latched.
  always_comb begin
    blank = '0;
  end
`endif

  // PWM gate: the leading bright+1 sub-slots of a slot are lit.
  always_comb begin
    en = (sub <= bright) && !blank[dig];
  end

  // Registered outputs, one cycle behind the counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg   <= '0;
      an    <= '0;
      frame <= 1'b0;
    end else begin
      seg   <= en ? disp[dig] : 7'b0;
      an    <= en ? (4'b0001 << dig) : 4'b0;
      frame <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed, table-driven bench for seg_scan_driver
// with CLK_DIV=2 (16-cycle slot, 64-cycle frame). Builds with or without
// SEG_SCAN_LZB_EN; blanking expectations follow the macro.
module tb_seg_scan_driver;

  localparam int CLK_DIV = 2;

  localparam logic [6:0] P0 = 7'b0111111;
  localparam logic [6:0] P1 = 7'b0000110;
  localparam logic [6:0] P2 = 7'b1011011;
  localparam logic [6:0] P3 = 7'b1001111;
  localparam logic [6:0] P4 = 7'b1100110;
  localparam logic [6:0] P5 = 7'b1101101;
  localparam logic [6:0] P6 = 7'b1111101;
  localparam logic [6:0] P7 = 7'b0000111;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] PZ = 7'b0000000;

`ifdef SEG_SCAN_LZB_EN
  localparam logic [3:0] VIS_0005 = 4'b0001;
  localparam logic [3:0] VIS_0700 = 4'b0111;
  localparam logic [3:0] VIS_0000 = 4'b0001;
`else
  localparam logic [3:0] VIS_0005 = 4'b1111;
  localparam logic [3:0] VIS_0700 = 4'b1111;
  localparam logic [3:0] VIS_0000 = 4'b1111;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg1 = '0, seg2 = '0, seg3 = '0, seg4 = '0;
  logic       load = 1'b0;
  logic [2:0] bright = 3'd7;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [2:0] bright;
    logic [6:0] s1, s2, s3, s4;
    logic [3:0] vis;
  } vec_t;

  vec_t vecs[7];

  seg_scan_driver #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst),
    .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4),
    .load(load), .bright(bright),
    .seg(seg), .an(an), .frame(frame)
  );

  // clock
  always #5 clk = ~clk;

  task automatic compare(input string name, input int cyc,
                         input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got frame/an/seg=%b/%b/%b want %b/%b/%b",
               name, cyc, got[11], got[10:7], got[6:0],
               want[11], want[10:7], want[6:0]);
    end
  endtask

  task automatic pulse_load(input logic [6:0] l1, input logic [6:0] l2,
                            input logic [6:0] l3, input logic [6:0] l4);
    @(negedge clk);
    seg1 = l1; seg2 = l2; seg3 = l3; seg4 = l4;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (frame === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s frame pulse not seen within 200 cycles (got none, want 1)", name);
    end
  endtask

  // Checks one full 64-cycle frame starting at digit-1 cycle 0. Optionally
  // strobes load right after sampling cycle load_at, which lands the load in
  // counter cycle load_at+1 (62 -> the boundary cycle).
  task automatic check_frame(input string name,
                             input logic [6:0] e1, input logic [6:0] e2,
                             input logic [6:0] e3, input logic [6:0] e4,
                             input logic [2:0] b, input logic [3:0] vis,
                             input int load_at,
                             input logic [6:0] l1, input logic [6:0] l2,
                             input logic [6:0] l3, input logic [6:0] l4);
    logic [6:0]  e [4];
    logic [3:0]  ea;
    logic [6:0]  es;
    logic [11:0] want;
    e[0] = e1; e[1] = e2; e[2] = e3; e[3] = e4;
    for (int i = 0; i < 64; i++) begin
      int d;
      int s;
      bit lit;
      d   = i / 16;
      s   = (i % 16) / 2;
      lit = (s <= int'(b)) && vis[d];
      ea  = lit ? (4'b0001 << d) : 4'b0000;
      es  = lit ? e[d] : 7'b0;
      exp_q.push_back({(i == 63), ea, es});
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      want = exp_q.pop_front();
      compare(name, i, {frame, an, seg}, want);
      if (i == load_at) begin
        seg1 = l1; seg2 = l2; seg3 = l3; seg4 = l4;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  initial begin
    vecs[0] = '{3'd7, P1, P2, P3, P4, 4'b1111};
    vecs[1] = '{3'd0, P8, P8, P8, P8, 4'b1111};
    vecs[2] = '{3'd3, P5, P6, P7, P6, 4'b1111};
    vecs[3] = '{3'd5, P2, P0, P3, P1, 4'b1111};
    vecs[4] = '{3'd7, P5, P0, P0, P0, VIS_0005};
    vecs[5] = '{3'd7, P0, P0, P7, P0, VIS_0700};
    vecs[6] = '{3'd1, P0, P0, P0, P0, VIS_0000};

    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    compare("reset", 0, {frame, an, seg}, 12'b0);
    rst = 1'b0;

    // first frame after reset: blank patterns, load 4,3,2,1 in cycle 1
    check_frame("first", PZ, PZ, PZ, PZ, 3'd7, 4'b1111, 0, P1, P2, P3, P4);
    check_frame("shown", P1, P2, P3, P4, 3'd7, 4'b1111, -1, PZ, PZ, PZ, PZ);

    // mid-frame load stays hidden until the boundary
    check_frame("mid_old", P1, P2, P3, P4, 3'd7, 4'b1111, 20, P5, P6, P7, P8);
    // load in the boundary cycle takes effect in the very next slot
    check_frame("mid_new", P5, P6, P7, P8, 3'd7, 4'b1111, 62, P8, P7, P6, P5);
    check_frame("bnd_load", P8, P7, P6, P5, 3'd7, 4'b1111, -1, PZ, PZ, PZ, PZ);

    // two loads in one frame: last wins
    pulse_load(P1, P1, P1, P1);
    pulse_load(P8, P8, P8, P8);
    wait_frame("two_loads");
    check_frame("two_loads", P8, P8, P8, P8, 3'd7, 4'b1111, -1, PZ, PZ, PZ, PZ);

    // reset mid-slot with a pending load: scan restarts, load discarded
    repeat (5) @(negedge clk);
    pulse_load(P5, P5, P5, P5);
    rst = 1'b1;
    @(negedge clk);
    compare("rst_mid", 0, {frame, an, seg}, 12'b0);
    rst = 1'b0;
    check_frame("after_rst", PZ, PZ, PZ, PZ, 3'd7, 4'b1111, -1, PZ, PZ, PZ, PZ);
    check_frame("discarded", PZ, PZ, PZ, PZ, 3'd7, 4'b1111, -1, PZ, PZ, PZ, PZ);

    // table vectors: brightness levels and blanking patterns
    for (int v = 0; v < 7; v++) begin
      bright = vecs[v].bright;
      pulse_load(vecs[v].s1, vecs[v].s2, vecs[v].s3, vecs[v].s4);
      wait_frame($sformatf("vec%0d_wait", v));
      check_frame($sformatf("vec%0d", v), vecs[v].s1, vecs[v].s2, vecs[v].s3,
                  vecs[v].s4, vecs[v].bright, vecs[v].vis, -1, PZ, PZ, PZ, PZ);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
